// File: rtl/irq_arbiter.sv
// Fixed-priority interrupt arbiter for seven edge-triggered sources.
// Sources 0-3 are asynchronous push buttons (2-flop synchronized); sources 4-6
// are clk-synchronous peripheral levels. Rising edges on enabled sources latch
// into pending bits. One source at a time is granted and held until eoi.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   btn          asynchronous push-button levels (sources 0-3)
//   uart_int     source 4 level
//   eth_1_int    source 5 level
//   eth_2_int    source 6 level
//   irq_mask     per-source enable, 1 = enabled
//   eoi          end-of-interrupt pulse from core
//   overrun_clr  pulse clearing all overrun flags
//   irq          one-hot vector, bit IRQ_BASE+irq_id set while in service
//   irq_id       index of the source in service
//   busy         high while a source is in service
//   overrun      sticky per-source lost-edge flags
module irq_arbiter #(
   parameter int unsigned NUM_SRC  = 7,
   parameter int unsigned IRQ_BASE = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [3:0]         btn,
   input  logic               uart_int,
   input  logic               eth_1_int,
   input  logic               eth_2_int,
   input  logic [NUM_SRC-1:0] irq_mask,
   input  logic               eoi,
   input  logic               overrun_clr,
   output logic [31:0]        irq,
   output logic [2:0]         irq_id,
   output logic               busy,
   output logic [NUM_SRC-1:0] overrun
);

   localparam int unsigned IRQ_W = 32;
   localparam int unsigned ID_W  = 3;
   localparam int unsigned BTN_W = 4;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   state_t             state;
   state_t             state_nxt;

   logic [BTN_W-1:0]   btn_s1;
   logic [BTN_W-1:0]   btn_s2;
   logic [NUM_SRC-1:0] src_lvl;
   logic [NUM_SRC-1:0] prev_lvl;
   logic [NUM_SRC-1:0] src_edge;
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] pending_nxt;
   logic [NUM_SRC-1:0] overrun_nxt;
   logic [NUM_SRC-1:0] eligible;
   logic [NUM_SRC-1:0] grant_onehot;
   logic [NUM_SRC-1:0] grant_clr;
   logic [ID_W-1:0]    grant_id;
   logic [IRQ_W-1:0]   irq_onehot;
   logic [IRQ_W-1:0]   irq_nxt;
   logic [ID_W-1:0]    irq_id_nxt;
   logic               busy_nxt;
   logic               found;

   // Fixed source map; only buttons go through the synchronizer.
   assign src_lvl  = {eth_2_int, eth_1_int, uart_int, btn_s2};
   assign src_edge = src_lvl & ~prev_lvl;
   assign eligible = pending & irq_mask;

   // Lowest-index eligible source wins.
   always_comb begin
      grant_id     = '0;
      grant_onehot = '0;
      found        = 1'b0;
      for (int i = 0; i < int'(NUM_SRC); i++) begin
         if (eligible[i] && !found) begin
            found           = 1'b1;
            grant_id        = ID_W'(i);
            grant_onehot[i] = 1'b1;
         end
      end
   end

   // Map the granted source onto its irq vector bit.
   always_comb begin
      irq_onehot = '0;
      for (int i = 0; i < int'(NUM_SRC); i++) begin
         if (grant_onehot[i]) irq_onehot[IRQ_BASE + i] = 1'b1;
      end
   end

   // Next state and registered-output values.
   always_comb begin
      state_nxt  = state;
      irq_nxt    = irq;
      irq_id_nxt = irq_id;
      busy_nxt   = busy;
      grant_clr  = '0;
      case (state)
         IDLE: begin
            if (|eligible) begin
               state_nxt  = ACTIVE;
               irq_id_nxt = grant_id;
               irq_nxt    = irq_onehot;
               busy_nxt   = 1'b1;
               grant_clr  = grant_onehot;
            end
         end
         ACTIVE: begin
            // Grant is held regardless of mask changes until eoi.
            if (eoi) begin
               state_nxt = IDLE;
               irq_nxt   = '0;
               busy_nxt  = 1'b0;
            end
         end
         default: begin
            state_nxt = IDLE;
            irq_nxt   = '0;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   // A new edge on a granted source re-pends it; the old event was consumed,
   // so that edge is not an overrun. Masked edges are dropped.
   always_comb begin
      pending_nxt = (pending & ~grant_clr) | (src_edge & irq_mask);
      overrun_nxt = (overrun & ~{NUM_SRC{overrun_clr}})
                  | (src_edge & pending & ~grant_clr);
   end

   // State register and all sequential storage.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         btn_s1   <= '0;
         btn_s2   <= '0;
         prev_lvl <= '0;
         pending  <= '0;
         overrun  <= '0;
         irq      <= '0;
         irq_id   <= '0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         btn_s1   <= btn;
         btn_s2   <= btn_s1;
         prev_lvl <= src_lvl;
         pending  <= pending_nxt;
         overrun  <= overrun_nxt;
         irq      <= irq_nxt;
         irq_id   <= irq_id_nxt;
         busy     <= busy_nxt;
      end
   end

endmodule
